hls_axis_block_detector: RTL and testbench

Generates the per-channel `axis_block_sigs` vector consumed by the HLS deadlock monitors. Watches the tvalid/tready pair of each AXI-Stream channel around an HLS instance and flags a channel as blocked once it has stalled for THRESHOLD consecutive cycles. A channel stalls when valid is high and ready is low. The block also latches the index of the first channel to block, for debug readout, until software or the scheduler clears it.

---
 rtl/hls_axis_block_detector.sv | 122 ++++++++++++
 tb/tb_hls_axis_block_detector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hls_axis_block_detector.sv
// Per-channel AXI-Stream stall detector feeding the HLS deadlock monitors.
// Each lane counts consecutive stall cycles; the top latches the first lane to block.

module hls_axis_block_lane #(
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = $clog2(THRESHOLD + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_stall,
    output logic o_hit,
    output logic o_flag
);
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt;

    // Saturate at THR so a stall of any length holds the flag without wrapping.
    always_comb begin
        w_nxt = '0;
        if (i_stall) begin
            w_nxt = (r_cnt == THR) ? THR : r_cnt + 1'b1;
        end
    end

    assign o_hit = (w_nxt == THR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            o_flag <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            o_flag <= 1'b0;
        end else begin
            r_cnt  <= w_nxt;
            o_flag <= o_hit;
        end
    end
endmodule

module hls_axis_block_detector #(
    parameter  int NUM_CHAN  = 5,
    parameter  int THRESHOLD = 16,
    localparam int CNT_W     = $clog2(THRESHOLD + 1),
    localparam int IDX_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_CHAN-1:0] axis_tvalid,
    input  logic [NUM_CHAN-1:0] axis_tready,
    input  logic                clear,
    output logic [NUM_CHAN-1:0] axis_block_sigs,
    output logic                any_block,
    output logic                first_block_valid,
    output logic [IDX_W-1:0]    first_block_idx
);
    typedef enum logic {S_IDLE, S_CAPT} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt, w_low;
    logic [NUM_CHAN-1:0] w_stall, w_hit;

    assign w_stall = axis_tvalid & ~axis_tready;

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_lane
        hls_axis_block_lane #(
            .THRESHOLD(THRESHOLD),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .i_clear(clear),
            .i_stall(w_stall[g]),
            .o_hit  (w_hit[g]),
            .o_flag (axis_block_sigs[g])
        );
    end

    // Descending scan leaves the lowest hitting index in w_low.
    always_comb begin
        w_low = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (w_hit[i]) w_low = IDX_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: if (|w_hit) begin
                    w_state_nxt = S_CAPT;
                    w_idx_nxt   = w_low;
                end
                S_CAPT: w_state_nxt = S_CAPT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            any_block <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            any_block <= clear ? 1'b0 : |w_hit;
        end
    end

    assign first_block_valid = (r_state == S_CAPT);
    assign first_block_idx   = r_idx;
endmodule

// File: tb/tb_hls_axis_block_detector.sv
// Scoreboard bench: stimulus pushes expected outputs from a run-length model,
// a monitor pops and compares one entry after every rising edge.

module tb_hls_axis_block_detector;
    localparam int NC  = 5;
    localparam int THR = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [NC-1:0] axis_tvalid = '0;
    logic [NC-1:0] axis_tready = '0;
    logic [NC-1:0] axis_block_sigs;
    logic          any_block;
    logic          first_block_valid;
    logic [2:0]    first_block_idx;

    hls_axis_block_detector #(.NUM_CHAN(NC), .THRESHOLD(THR)) dut (
        .clock            (clock),
        .reset            (reset),
        .axis_tvalid      (axis_tvalid),
        .axis_tready      (axis_tready),
        .clear            (clear),
        .axis_block_sigs  (axis_block_sigs),
        .any_block        (any_block),
        .first_block_valid(first_block_valid),
        .first_block_idx  (first_block_idx)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NC-1:0] sigs;
        logic          any;
        logic          fv;
        logic [2:0]    idx;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   runs[NC];
    int   first = -1;
    int   cyc = 0;
    bit   done = 0;

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
        end
    endtask

    // Model: a channel is blocked when its current run of consecutive stalls is >= THR.
    task automatic step(input logic [NC-1:0] v, input logic [NC-1:0] r,
                        input logic c, input logic rs);
        exp_t e;
        @(negedge clock);
        axis_tvalid = v;
        axis_tready = r;
        clear       = c;
        reset       = rs;
        for (int i = 0; i < NC; i++) begin
            if (rs || c) runs[i] = 0;
            else runs[i] = (v[i] && !r[i]) ? runs[i] + 1 : 0;
        end
        if (rs || c) first = -1;
        e = '0;
        for (int i = 0; i < NC; i++) e.sigs[i] = (runs[i] >= THR);
        e.any = (e.sigs != 0);
        if (first < 0) begin
            for (int i = NC - 1; i >= 0; i--) if (e.sigs[i]) first = i;
        end
        e.fv  = (first >= 0);
        e.idx = (first >= 0) ? 3'(first) : 3'd0;
        q.push_back(e);
    endtask

    task automatic rep(input int n, input logic [NC-1:0] v, input logic [NC-1:0] r,
                       input logic c, input logic rs);
        for (int k = 0; k < n; k++) step(v, r, c, rs);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("axis_block_sigs", int'(axis_block_sigs), int'(e.sigs));
                chk("any_block", int'(any_block), int'(e.any));
                chk("first_block_valid", int'(first_block_valid), int'(e.fv));
                chk("first_block_idx", int'(first_block_idx), int'(e.idx));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete in time");
            $fatal(1, "timeout");
        end
    end

    initial begin : stim
        for (int i = 0; i < NC; i++) runs[i] = 0;
        // Reset held with every channel stalled, then ch0 keeps stalling.
        rep(3, 5'b11111, 5'b00000, 1'b0, 1'b1);
        rep(6, 5'b00001, 5'b00000, 1'b0, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        // ch2 threshold edge: 3 stalls (no flag), then 4 stalls (flag), then release.
        rep(3, 5'b00100, 5'b00000, 1'b0, 1'b0);
        step(5'b00100, 5'b00100, 1'b0, 1'b0);
        rep(4, 5'b00100, 5'b00000, 1'b0, 1'b0);
        rep(2, 5'b00100, 5'b00100, 1'b0, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        // Idle is not a stall.
        rep(20, 5'b00000, 5'b00000, 1'b0, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        // Simultaneous ch1/ch3, then ch1 released and ch4 stalled.
        rep(5, 5'b01010, 5'b00000, 1'b0, 1'b0);
        rep(6, 5'b11000, 5'b00010, 1'b0, 1'b0);
        // ch4 captured, then clear pulse while ch4 stays stalled.
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        rep(5, 5'b10000, 5'b00000, 1'b0, 1'b0);
        step(5'b10000, 5'b00000, 1'b1, 1'b0);
        rep(6, 5'b10000, 5'b00000, 1'b0, 1'b0);
        // Async reset mid-capture must act before any clock edge.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_sigs", int'(axis_block_sigs), 0);
        chk("async_reset_fv", int'(first_block_valid), 0);
        chk("async_reset_any", int'(any_block), 0);
        step(5'b10000, 5'b00000, 1'b0, 1'b1);
        rep(5, 5'b10000, 5'b00000, 1'b0, 1'b0);
        step(5'b00000, 5'b00000, 1'b1, 1'b0);
        // Saturation: long stall on ch0, then a single ready cycle.
        rep(1000, 5'b00001, 5'b00000, 1'b0, 1'b0);
        step(5'b00001, 5'b00001, 1'b0, 1'b0);
        rep(2, 5'b00000, 5'b00000, 1'b0, 1'b0);
        // Random traffic biased toward stalls, with occasional clear and reset.
        for (int k = 0; k < 2000; k++) begin
            logic [NC-1:0] v, r;
            logic c, rs;
            v = '0;
            r = '0;
            for (int i = 0; i < NC; i++) begin
                v[i] = ($urandom_range(0, 7) != 0);
                r[i] = ($urandom_range(0, 9) == 0);
            end
            c  = ($urandom_range(0, 63) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(v, r, c, rs);
        end
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
